// File: rtl/flood_reveal.sv
// flood_reveal: iterative flood-fill reveal engine owning the cumulative Saper reveal map.
// Optional macro FLOOD_DIAG_EN: firing cells also propagate to the 4 diagonal neighbours.
//
// state | meaning
// IDLE  | wait for start or clear
// SEED  | reveal the selected cell, decide whether a sweep is needed
// SCAN  | raster sweep, one cell per clock, repeated until a pass changes nothing
// DONE  | one-cycle done pulse
module flood_reveal #(
  parameter int MAX_DIM = 16,
  parameter int ADDR_W  = 4,
  parameter int PCNT_W  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             clear,
  input  logic [ADDR_W:0]                  dim,
  input  logic [ADDR_W-1:0]                sel_x,
  input  logic [ADDR_W-1:0]                sel_y,
  input  logic [MAX_DIM-1:0][MAX_DIM-1:0]  mine_arr,
  output logic [MAX_DIM-1:0][MAX_DIM-1:0]  reveal_arr,
  output logic                             busy,
  output logic                             done,
  output logic                             hit,
  output logic [PCNT_W-1:0]                pass_cnt
);

`ifdef FLOOD_DIAG_EN
  localparam bit DIAG_EN = 1'b1;
`else
  localparam bit DIAG_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SEED, S_SCAN, S_DONE} state_t;

  state_t            state, state_nx;
  logic [ADDR_W:0]   dim_q;
  logic [ADDR_W-1:0] selx_q, sely_q;
  logic [ADDR_W-1:0] sx, sy;
  logic              changed;

  logic [ADDR_W-1:0] cx, cy;
  logic [ADDR_W-1:0] nx [3];
  logic [ADDR_W-1:0] ny [3];
  logic [2:0]        xok, yok;
  logic [2:0][2:0]   prop;
  logic [3:0]        mcnt;
  logic              fire, grow, last_cell, sel_oor;

  // The neighbourhood logic is shared between SEED (selected cell) and SCAN (raster cell).
  always_comb begin
    cx    = (state == S_SEED) ? selx_q : sx;
    cy    = (state == S_SEED) ? sely_q : sy;
    nx[0] = cx - 1'b1;
    nx[1] = cx;
    nx[2] = cx + 1'b1;
    ny[0] = cy - 1'b1;
    ny[1] = cy;
    ny[2] = cy + 1'b1;
    xok   = {(({1'b0, cx} + 1'b1) < dim_q), 1'b1, (cx != '0)};
    yok   = {(({1'b0, cy} + 1'b1) < dim_q), 1'b1, (cy != '0)};
  end

  always_comb begin
    mcnt = '0;
    prop = '0;
    grow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (!(i == 1 && j == 1) && xok[i] && yok[j]) begin
          if (mine_arr[nx[i]][ny[j]]) mcnt = mcnt + 4'd1;
          else if (DIAG_EN || i == 1 || j == 1) prop[i][j] = 1'b1;
        end
      end
    end
    fire = (state == S_SCAN) && reveal_arr[cx][cy] && !mine_arr[cx][cy] && (mcnt == 4'd0);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (fire && prop[i][j] && !reveal_arr[nx[i]][ny[j]]) grow = 1'b1;
      end
    end
    last_cell = ({1'b0, sx} == dim_q - 1'b1) && ({1'b0, sy} == dim_q - 1'b1);
    sel_oor   = ({1'b0, selx_q} >= dim_q) || ({1'b0, sely_q} >= dim_q);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (!clear && start) state_nx = S_SEED;
      S_SEED: begin
        if (sel_oor || mine_arr[selx_q][sely_q] || mcnt != 4'd0) state_nx = S_DONE;
        else                                                      state_nx = S_SCAN;
      end
      S_SCAN: if (last_cell && !(changed || grow)) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state == S_SEED) || (state == S_SCAN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      reveal_arr <= '0;
      hit        <= 1'b0;
      pass_cnt   <= '0;
      dim_q      <= '0;
      selx_q     <= '0;
      sely_q     <= '0;
      sx         <= '0;
      sy         <= '0;
      changed    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear) begin
            reveal_arr <= '0;
            hit        <= 1'b0;
          end else if (start) begin
            dim_q    <= dim;
            selx_q   <= sel_x;
            sely_q   <= sel_y;
            hit      <= 1'b0;
            pass_cnt <= '0;
          end
        end
        S_SEED: begin
          if (!sel_oor) begin
            reveal_arr[selx_q][sely_q] <= 1'b1;
            if (mine_arr[selx_q][sely_q]) hit <= 1'b1;
          end
          sx      <= '0;
          sy      <= '0;
          changed <= 1'b0;
        end
        S_SCAN: begin
          if (fire) begin
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                if (prop[i][j]) reveal_arr[nx[i]][ny[j]] <= 1'b1;
          end
          if (grow) changed <= 1'b1;
          if (last_cell) begin
            if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
            changed <= 1'b0;
            sx      <= '0;
            sy      <= '0;
          end else if ({1'b0, sy} == dim_q - 1'b1) begin
            sy <= '0;
            sx <= sx + 1'b1;
          end else begin
            sy <= sy + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flood_reveal.sv
// Bench for flood_reveal: directed and random boards checked against a pass-by-pass sweep model.
module tb_flood_reveal;
  localparam int MD = 16;
  localparam int AW = 4;
  localparam int PW = 8;

`ifdef FLOOD_DIAG_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst, start, clear;
  logic [AW:0]               dim;
  logic [AW-1:0]             sel_x, sel_y;
  logic [MD-1:0][MD-1:0]     mine_arr, reveal_arr;
  logic                      busy, done, hit;
  logic [PW-1:0]             pass_cnt;

  flood_reveal #(.MAX_DIM(MD), .ADDR_W(AW), .PCNT_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .dim(dim),
    .sel_x(sel_x), .sel_y(sel_y), .mine_arr(mine_arr), .reveal_arr(reveal_arr),
    .busy(busy), .done(done), .hit(hit), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit mines [MD][MD];
  bit mrev  [MD][MD];
  bit mhit;
  int mpass;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_map();
    logic [255:0] r = '0;
    for (int x = 0; x < MD; x++)
      for (int y = 0; y < MD; y++)
        r[x*MD+y] = mrev[x][y];
    return r;
  endfunction

  function automatic int mcount(input int x, input int y, input int d);
    int c = 0;
    for (int dx = -1; dx <= 1; dx++)
      for (int dy = -1; dy <= 1; dy++) begin
        int px;
        int py;
        px = x + dx;
        py = y + dy;
        if ((dx != 0 || dy != 0) && px >= 0 && px < d && py >= 0 && py < d && mines[px][py]) c++;
      end
    return c;
  endfunction

  task automatic model_op(input int d, input int sx, input int sy, output int lat);
    int p;
    bit ch;
    mhit  = 1'b0;
    mpass = 0;
    lat   = 2;
    if (sx >= d || sy >= d) return;
    mrev[sx][sy] = 1'b1;
    if (mines[sx][sy]) begin
      mhit = 1'b1;
      return;
    end
    if (mcount(sx, sy, d) != 0) return;
    p = 0;
    do begin
      ch = 1'b0;
      for (int x = 0; x < d; x++)
        for (int y = 0; y < d; y++)
          if (mrev[x][y] && !mines[x][y] && mcount(x, y, d) == 0)
            for (int dx = -1; dx <= 1; dx++)
              for (int dy = -1; dy <= 1; dy++) begin
                int px;
                int py;
                px = x + dx;
                py = y + dy;
                if ((dx != 0 || dy != 0) && (DIAG || dx == 0 || dy == 0) &&
                    px >= 0 && px < d && py >= 0 && py < d &&
                    !mines[px][py] && !mrev[px][py]) begin
                  mrev[px][py] = 1'b1;
                  ch = 1'b1;
                end
              end
      p++;
    end while (ch);
    mpass = (p > 255) ? 255 : p;
    lat   = 2 + p * d * d;
  endtask

  task automatic load_mines();
    for (int x = 0; x < MD; x++)
      for (int y = 0; y < MD; y++)
        mine_arr[x][y] = mines[x][y];
  endtask

  task automatic no_mines();
    for (int x = 0; x < MD; x++)
      for (int y = 0; y < MD; y++)
        mines[x][y] = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    for (int x = 0; x < MD; x++)
      for (int y = 0; y < MD; y++)
        mrev[x][y] = 1'b0;
    mhit = 1'b0;
    check("clear_map", 256'(reveal_arr), 256'(0));
  endtask

  task automatic do_op(input string tag, input int d, input int sx, input int sy, input bit poke,
                       output int cyc_out);
    int lat;
    int cyc;
    load_mines();
    model_op(d, sx, sy, lat);
    @(negedge clk);
    dim   = (AW+1)'(d);
    sel_x = AW'(sx);
    sel_y = AW'(sy);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_busy1"}, 256'(busy), 256'(1));
    cyc = 1;
    while (done !== 1'b1 && cyc < 30000) begin
      if (poke && cyc == 20) begin
        start = 1'b1;
        sel_x = AW'(d - 1);
        sel_y = AW'(d - 1);
      end
      @(posedge clk);
      #1 start = 1'b0;
      cyc++;
    end
    check({tag, "_latency"}, 256'(cyc), 256'(lat));
    check({tag, "_busy_at_done"}, 256'(busy), 256'(0));
    check({tag, "_map"}, 256'(reveal_arr), model_map());
    check({tag, "_hit"}, 256'(hit), 256'(mhit));
    check({tag, "_pass"}, 256'(pass_cnt), 256'(mpass));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 256'(done), 256'(0));
    cyc_out = cyc;
  endtask

  initial begin
    int cyc;
    int d;
    rst = 1'b1; start = 1'b0; clear = 1'b0;
    dim = 5'd8; sel_x = '0; sel_y = '0;
    no_mines();
    load_mines();
    for (int x = 0; x < MD; x++)
      for (int y = 0; y < MD; y++)
        mrev[x][y] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_map", 256'(reveal_arr), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_hit", 256'(hit), 256'(0));
    check("rst_pass", 256'(pass_cnt), 256'(0));

    // empty 8x8 board from the corner
    do_op("empty8", 8, 0, 0, 1'b0, cyc);
    check("empty8_pop", 256'($countones(reveal_arr)), 256'(64));
    check("empty8_pass_const", 256'(pass_cnt), 256'(2));
    check("empty8_lat_const", 256'(cyc), 256'(130));

    // click on a mine
    do_clear();
    no_mines();
    mines[3][4] = 1'b1;
    do_op("mine", 8, 3, 4, 1'b0, cyc);
    check("mine_hit_const", 256'(hit), 256'(1));
    repeat (4) @(posedge clk);
    #1 check("mine_hit_held", 256'(hit), 256'(1));

    // clear together with start: clear wins, no operation
    @(negedge clk);
    clear = 1'b1; start = 1'b1; dim = 5'd8; sel_x = '0; sel_y = '0;
    @(posedge clk);
    #1 clear = 1'b0; start = 1'b0;
    for (int x = 0; x < MD; x++)
      for (int y = 0; y < MD; y++)
        mrev[x][y] = 1'b0;
    mhit = 1'b0;
    check("clrstart_busy", 256'(busy), 256'(0));
    check("clrstart_map", 256'(reveal_arr), 256'(0));
    check("clrstart_hit", 256'(hit), 256'(0));
    @(posedge clk);
    #1 check("clrstart_busy2", 256'(busy), 256'(0));

    // nonzero count next to the click
    no_mines();
    mines[3][3] = 1'b1;
    do_op("count", 8, 2, 2, 1'b0, cyc);

    // wall of mines at x=5 on a 10x10 board
    do_clear();
    no_mines();
    for (int y = 0; y < 10; y++) mines[5][y] = 1'b1;
    do_op("wall", 10, 0, 0, 1'b0, cyc);
    check("wall_pop", 256'($countones(reveal_arr)), 256'(50));

    // out-of-range click leaves the map untouched
    do_op("oor", 8, 9, 2, 1'b0, cyc);

    // full board from the far corner
    do_clear();
    no_mines();
    do_op("full16", 16, 15, 15, 1'b0, cyc);
    check("full16_pop", 256'($countones(reveal_arr)), 256'(256));

    // start while busy is ignored
    do_clear();
    do_op("poke", 8, 0, 0, 1'b1, cyc);

    // random boards, cumulative reveal map
    for (int it = 0; it < 8; it++) begin
      case ($urandom_range(0, 2))
        0: d = 8;
        1: d = 10;
        default: d = 16;
      endcase
      if ($urandom_range(0, 2) == 0) do_clear();
      for (int x = 0; x < MD; x++)
        for (int y = 0; y < MD; y++)
          mines[x][y] = ($urandom_range(0, 99) < 12);
      do_op("rand", d, $urandom_range(0, 15), $urandom_range(0, 15), 1'b0, cyc);
    end

    // reset in the middle of a sweep
    do_clear();
    no_mines();
    load_mines();
    @(negedge clk);
    dim = 5'd16; sel_x = '0; sel_y = '0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #1 check("midscan_busy", 256'(busy), 256'(1));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rstscan_map", 256'(reveal_arr), 256'(0));
    check("rstscan_busy", 256'(busy), 256'(0));
    check("rstscan_done", 256'(done), 256'(0));
    check("rstscan_hit", 256'(hit), 256'(0));
    check("rstscan_pass", 256'(pass_cnt), 256'(0));
    for (int x = 0; x < MD; x++)
      for (int y = 0; y < MD; y++)
        mrev[x][y] = 1'b0;
    mines[2][2] = 1'b1;
    do_op("after_rst", 8, 0, 0, 1'b0, cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
